// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared state encoding, default timing constants and counter
//                width helper for the push-button debouncer.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 250000;
    localparam int DEFAULT_LONG_CYCLES   = 25000000;
    localparam bit DEFAULT_INVERT        = 1'b0;

    typedef enum logic [2:0] {
        RELEASED        = 3'd0,
        PRESS_PENDING   = 3'd1,
        PRESSED         = 3'd2,
        LONG_HELD       = 3'd3,
        RELEASE_PENDING = 3'd4
    } state_t;

    // Never return zero so a 1-cycle setting still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync2_rst_n.sv
`default_nettype none
// ============================================================================
//  Module      : sync2_rst_n
//  Description : Two-flop synchroniser, asynchronous active-low reset to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2_rst_n (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Push-button debouncer with level, press/release/long-press
//                pulses and a wrapping 8-bit press counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES,
    parameter bit INVERT        = DEFAULT_INVERT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_i,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       long_held,
    output logic [7:0] press_count
);

    localparam int c_cnt_w  = cnt_width(STABLE_CYCLES);
    localparam int c_hcnt_w = cnt_width(LONG_CYCLES);
    localparam logic [c_cnt_w-1:0]  c_stable_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_hcnt_w-1:0] c_long_last   = c_hcnt_w'(LONG_CYCLES - 1);

    logic                w_btn;
    logic                w_sync;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [c_hcnt_w-1:0] r_hcnt;
    logic [c_hcnt_w-1:0] w_hcnt_nxt;
    logic                w_press_evt;
    logic                w_release_evt;
    logic                w_long_evt;
    logic                r_pressed;
    logic                r_press_pulse;
    logic                r_release_pulse;
    logic                r_long_pulse;
    logic                r_long_held;
    logic [7:0]          r_press_count;

    assign w_btn = btn_i ^ INVERT;

    sync2_rst_n u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_btn),
        .o_q   (w_sync)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hcnt_nxt    = r_hcnt;
        w_press_evt   = 1'b0;
        w_release_evt = 1'b0;
        w_long_evt    = 1'b0;
        case (r_state)
            RELEASED: begin
                if (w_sync) begin
                    w_state_nxt = PRESS_PENDING;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_PENDING: begin
                if (!w_sync) begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_stable_last) begin
                    w_state_nxt = PRESSED;
                    w_press_evt = 1'b1;
                    w_hcnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!w_sync) begin
                    w_state_nxt = RELEASE_PENDING;
                    w_cnt_nxt   = '0;
                end else if (r_hcnt == c_long_last) begin
                    w_state_nxt = LONG_HELD;
                    w_long_evt  = 1'b1;
                end else begin
                    w_hcnt_nxt = r_hcnt + 1'b1;
                end
            end
            LONG_HELD: begin
                if (!w_sync) begin
                    w_state_nxt = RELEASE_PENDING;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_PENDING: begin
                // A bounce resumes the hold phase it interrupted; hcnt stays frozen.
                if (w_sync) begin
                    w_state_nxt = r_long_held ? LONG_HELD : PRESSED;
                end else if (r_cnt == c_stable_last) begin
                    w_state_nxt   = RELEASED;
                    w_release_evt = 1'b1;
                    w_hcnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = RELEASED;
                w_cnt_nxt   = '0;
                w_hcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= RELEASED;
            r_cnt           <= '0;
            r_hcnt          <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_long_held     <= 1'b0;
            r_press_count   <= 8'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_hcnt          <= w_hcnt_nxt;
            r_pressed       <= (w_state_nxt == PRESSED) || (w_state_nxt == LONG_HELD)
                               || (w_state_nxt == RELEASE_PENDING);
            r_press_pulse   <= w_press_evt;
            r_release_pulse <= w_release_evt;
            r_long_pulse    <= w_long_evt;
            if (w_long_evt) begin
                r_long_held <= 1'b1;
            end else if (w_release_evt) begin
                r_long_held <= 1'b0;
            end
            if (w_press_evt) begin
                r_press_count <= r_press_count + 8'd1;
            end
        end
    end

    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign long_pulse    = r_long_pulse;
    assign long_held     = r_long_held;
    assign press_count   = r_press_count;

endmodule
`default_nettype wire
